// File: rtl/service_gate_sequencer.sv
// Sequences one register-transfer microorder per accept through RD, CLR and WR.
// Gate outputs are registered and glitch-free. Optional carry-in flop enabled by SERVICE_GATE_CIFF_EN.
module service_gate_sequencer #(
  parameter int NREG = 8,
  parameter int SCW  = 3,
  localparam int RW  = ($clog2(NREG) < 1) ? 1 : $clog2(NREG),
  localparam int NSC = 1 << SCW
) (
  input  logic            SIM_CLK,
  input  logic            SIM_RST,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic            REQ_RD_EN,
  input  logic [RW-1:0]   REQ_RSEL,
  input  logic [NREG-1:0] REQ_WMASK,
  input  logic            REQ_SCR,
  input  logic            REQ_SCW,
  input  logic [SCW-1:0]  REQ_XB,
  input  logic            REQ_CI,
  output logic [NREG-1:0] RG,
  output logic [NREG-1:0] CG,
  output logic [NREG-1:0] WG,
  output logic [NSC-1:0]  SC_RD,
  output logic [NSC-1:0]  SC_WR,
  output logic            CI01,
  output logic            BUSY,
  output logic            ERR
);

  typedef enum logic [1:0] {IDLE, RD, CLR, WR} state_t;

  state_t state, state_nxt;

  logic            h_rd_en, h_scr, h_scw;
  logic [RW-1:0]   h_rsel;
  logic [NREG-1:0] h_wmask;
  logic [SCW-1:0]  h_xb;

  logic            f_rd_en, f_scr, f_scw, rsel_ok, accept;
  logic [RW-1:0]   f_rsel;
  logic [NREG-1:0] f_wmask;
  logic [SCW-1:0]  f_xb;

  logic [NREG-1:0] rg_nxt, cg_nxt, wg_nxt;
  logic [NSC-1:0]  sc_rd_nxt, sc_wr_nxt;
  logic            err_nxt;

  assign REQ_READY = (state == IDLE) || (state == WR);
  assign BUSY      = (state != IDLE);
  assign accept    = REQ_VALID && REQ_READY;

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) state <= IDLE;
    else         state <= state_nxt;
  end

  // Outputs are decoded from where the FSM is going, using the fields it will hold there.
  always_comb begin
    state_nxt = state;
    f_rd_en   = h_rd_en;
    f_scr     = h_scr;
    f_scw     = h_scw;
    f_rsel    = h_rsel;
    f_wmask   = h_wmask;
    f_xb      = h_xb;
    rg_nxt    = '0;
    cg_nxt    = '0;
    wg_nxt    = '0;
    sc_rd_nxt = '0;
    sc_wr_nxt = '0;
    err_nxt   = 1'b0;

    case (state)
      IDLE:    if (accept) state_nxt = RD;
      RD:      state_nxt = CLR;
      CLR:     state_nxt = WR;
      WR:      state_nxt = accept ? RD : IDLE;
      default: state_nxt = IDLE;
    endcase

    if (accept) begin
      f_rd_en = REQ_RD_EN;
      f_scr   = REQ_SCR;
      f_scw   = REQ_SCW;
      f_rsel  = REQ_RSEL;
      f_wmask = REQ_WMASK;
      f_xb    = REQ_XB;
    end

    rsel_ok = (32'(f_rsel) < 32'(NREG));

    if (state_nxt != IDLE) begin
      if (f_scr)                  sc_rd_nxt = NSC'(1) << f_xb;
      else if (f_rd_en && rsel_ok) rg_nxt   = NREG'(1) << f_rsel;
    end
    if (state_nxt == RD)  err_nxt = f_rd_en && !f_scr && !rsel_ok;
    if (state_nxt == CLR) cg_nxt  = f_wmask;
    if (state_nxt == WR) begin
      wg_nxt = f_wmask;
      if (f_scw) sc_wr_nxt = NSC'(1) << f_xb;
    end
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      h_rd_en <= 1'b0;
      h_scr   <= 1'b0;
      h_scw   <= 1'b0;
      h_rsel  <= '0;
      h_wmask <= '0;
      h_xb    <= '0;
    end else if (accept) begin
      h_rd_en <= REQ_RD_EN;
      h_scr   <= REQ_SCR;
      h_scw   <= REQ_SCW;
      h_rsel  <= REQ_RSEL;
      h_wmask <= REQ_WMASK;
      h_xb    <= REQ_XB;
    end
  end

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      RG    <= '0;
      CG    <= '0;
      WG    <= '0;
      SC_RD <= '0;
      SC_WR <= '0;
      ERR   <= 1'b0;
    end else begin
      RG    <= rg_nxt;
      CG    <= cg_nxt;
      WG    <= wg_nxt;
      SC_RD <= sc_rd_nxt;
      SC_WR <= sc_wr_nxt;
      ERR   <= err_nxt;
    end
  end

`ifdef SERVICE_GATE_CIFF_EN
  logic h_ci;

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST)     h_ci <= 1'b0;
    else if (accept) h_ci <= REQ_CI;
  end

  // A new carry-in request wins over the clear from the microorder finishing WR.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST)                      CI01 <= 1'b0;
    else if (accept && REQ_CI)        CI01 <= 1'b1;
    else if (state == WR && !h_ci)    CI01 <= 1'b0;
  end
`else
  logic unused_ci;
  assign unused_ci = REQ_CI;
  assign CI01      = 1'b0;
`endif

endmodule

// File: tb/tb_service_gate_sequencer.sv
// Directed vector bench for service_gate_sequencer (NREG=8 main instance, NREG=6 for the illegal-RSEL case).
module tb_service_gate_sequencer;

`ifdef SERVICE_GATE_CIFF_EN
  localparam logic CIEN = 1'b1;
`else
  localparam logic CIEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       valid, rd_en, scr, scw, ci;
  logic [2:0] rsel, xb;
  logic [7:0] wmask;
  logic       ready, ci01, busy, err;
  logic [7:0] rg, cg, wg, sc_rd, sc_wr;

  logic       valid_b, rd_en_b;
  logic [2:0] rsel_b;
  logic       ready_b, ci01_b, busy_b, err_b;
  logic [5:0] rg_b, cg_b, wg_b;
  logic [7:0] sc_rd_b, sc_wr_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  service_gate_sequencer #(.NREG(8), .SCW(3)) dut (
    .SIM_CLK(clk), .SIM_RST(rst), .REQ_VALID(valid), .REQ_READY(ready),
    .REQ_RD_EN(rd_en), .REQ_RSEL(rsel), .REQ_WMASK(wmask), .REQ_SCR(scr),
    .REQ_SCW(scw), .REQ_XB(xb), .REQ_CI(ci), .RG(rg), .CG(cg), .WG(wg),
    .SC_RD(sc_rd), .SC_WR(sc_wr), .CI01(ci01), .BUSY(busy), .ERR(err)
  );

  service_gate_sequencer #(.NREG(6), .SCW(3)) dut_b (
    .SIM_CLK(clk), .SIM_RST(rst), .REQ_VALID(valid_b), .REQ_READY(ready_b),
    .REQ_RD_EN(rd_en_b), .REQ_RSEL(rsel_b), .REQ_WMASK(6'h00), .REQ_SCR(1'b0),
    .REQ_SCW(1'b0), .REQ_XB(3'd0), .REQ_CI(1'b0), .RG(rg_b), .CG(cg_b), .WG(wg_b),
    .SC_RD(sc_rd_b), .SC_WR(sc_wr_b), .CI01(ci01_b), .BUSY(busy_b), .ERR(err_b)
  );

  typedef struct {
    logic       vld, rd, scr, scw, ci;
    logic [2:0] rsel, xb;
    logic [7:0] wm;
    logic [7:0] e_rg, e_cg, e_wg, e_scrd, e_scwr;
    logic       e_rdy, e_busy, e_ci;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic [2:0] rs, input logic [7:0] wm,
                       input logic sr, input logic sw, input logic [2:0] x, input logic c);
    valid = v; rd_en = r; rsel = rs; wmask = wm; scr = sr; scw = sw; xb = x; ci = c;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_rg, input logic [7:0] e_cg,
                         input logic [7:0] e_wg, input logic [7:0] e_scrd, input logic [7:0] e_scwr,
                         input logic e_rdy, input logic e_busy, input logic e_ci);
    chk({tag, ".rg"},    32'(rg),    32'(e_rg));
    chk({tag, ".cg"},    32'(cg),    32'(e_cg));
    chk({tag, ".wg"},    32'(wg),    32'(e_wg));
    chk({tag, ".sc_rd"}, 32'(sc_rd), 32'(e_scrd));
    chk({tag, ".sc_wr"}, 32'(sc_wr), 32'(e_scwr));
    chk({tag, ".ready"}, 32'(ready), 32'(e_rdy));
    chk({tag, ".busy"},  32'(busy),  32'(e_busy));
    chk({tag, ".ci01"},  32'(ci01),  32'(e_ci & CIEN));
    chk({tag, ".err"},   32'(err),   32'd0);
  endtask

  initial begin
    //            vld rd scr scw ci  rsel  xb    wm      rg     cg     wg     scrd   scwr  rdy busy ci
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,8'h00, 8'h00,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,3'd2,3'd0,8'h11, 8'h04,8'h00,8'h00,8'h00,8'h00,1'b0,1'b1,1'b1};
    tbl[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd5,3'd0,8'h02, 8'h04,8'h11,8'h00,8'h00,8'h00,1'b0,1'b1,1'b1};
    tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd5,3'd0,8'h02, 8'h04,8'h00,8'h11,8'h00,8'h00,1'b1,1'b1,1'b1};
    tbl[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd5,3'd0,8'h02, 8'h20,8'h00,8'h00,8'h00,8'h00,1'b0,1'b1,1'b1};
    tbl[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,3'd1,3'd0,8'h80, 8'h20,8'h02,8'h00,8'h00,8'h00,1'b0,1'b1,1'b1};
    tbl[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,3'd1,3'd0,8'h80, 8'h20,8'h00,8'h02,8'h00,8'h00,1'b1,1'b1,1'b1};
    tbl[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,3'd1,3'd0,8'h80, 8'h02,8'h00,8'h00,8'h00,8'h00,1'b0,1'b1,1'b1};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,8'h00, 8'h02,8'h80,8'h00,8'h00,8'h00,1'b0,1'b1,1'b1};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,8'h00, 8'h02,8'h00,8'h80,8'h00,8'h00,1'b1,1'b1,1'b1};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b1,1'b0,3'd3,3'd5,8'h00, 8'h00,8'h00,8'h00,8'h20,8'h00,1'b0,1'b1,1'b1};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,8'h00, 8'h00,8'h00,8'h00,8'h20,8'h00,1'b0,1'b1,1'b1};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,8'h00, 8'h00,8'h00,8'h00,8'h20,8'h20,1'b1,1'b1,1'b1};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,8'h00, 8'h00,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0,1'b0};
    tbl[14] = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd7,3'd0,8'h00, 8'h80,8'h00,8'h00,8'h00,8'h00,1'b0,1'b1,1'b0};
    tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,8'h00, 8'h80,8'h00,8'h00,8'h00,8'h00,1'b0,1'b1,1'b0};
    tbl[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,8'h00, 8'h80,8'h00,8'h00,8'h00,8'h00,1'b1,1'b1,1'b0};
    tbl[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,8'h00, 8'h00,8'h00,8'h00,8'h00,8'h00,1'b1,1'b0,1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    valid_b = 1'b0; rd_en_b = 1'b0; rsel_b = 3'd0;
    step();
    step();
    chk_all("reset_idle", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // Each row: inputs driven before an edge, outputs expected just after it.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].vld, tbl[i].rd, tbl[i].rsel, tbl[i].wm, tbl[i].scr, tbl[i].scw, tbl[i].xb, tbl[i].ci);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].e_rg, tbl[i].e_cg, tbl[i].e_wg, tbl[i].e_scrd,
              tbl[i].e_scwr, tbl[i].e_rdy, tbl[i].e_busy, tbl[i].e_ci);
    end

    // Illegal read select on the 6-register instance.
    valid_b = 1'b1; rd_en_b = 1'b1; rsel_b = 3'd7;
    step();
    valid_b = 1'b0;
    chk("errb.err_rd",  32'(err_b),  32'd1);
    chk("errb.rg_rd",   32'(rg_b),   32'd0);
    chk("errb.busy_rd", 32'(busy_b), 32'd1);
    step();
    chk("errb.err_clr", 32'(err_b),  32'd0);
    chk("errb.rg_clr",  32'(rg_b),   32'd0);
    step();
    step();

    // Reset while in WR.
    drive(1'b1, 1'b1, 3'd2, 8'h11, 1'b0, 1'b0, 3'd0, 1'b1);
    step();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    step();
    chk("wrrst.wg_before", 32'(wg), 32'h11);
    #2 rst = 1'b1;
    #1 chk_all("wrrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset in the middle of CLR with a full mask.
    drive(1'b1, 1'b1, 3'd0, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b1);
    step();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    chk("clrrst.cg_before", 32'(cg), 32'hFF);
    chk("clrrst.ci_before", 32'(ci01), 32'(CIEN));
    #2 rst = 1'b1;
    #1 chk_all("clrrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("clrrst.wg_after1", 32'(wg), 32'h00);
    step();
    chk("clrrst.wg_after2", 32'(wg), 32'h00);
    drive(1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
    chk_all("postrst_rd", 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    step();
    step();
    chk_all("postrst_idle", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
